// File: rtl/arc4_crack_ctrl.sv
// Key-search controller: walks candidate keys through arc4, then scans the
// decrypted plaintext for printable bytes and reports the first passing key.
module arc4_crack_ctrl #(
    parameter int               KEY_W    = 24,
    parameter logic [KEY_W-1:0] KEY_INIT = '0,
    parameter logic [7:0]       CHAR_LO  = 8'h20,
    parameter logic [7:0]       CHAR_HI  = 8'h7E
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             a4_en,
    input  logic             a4_rdy,
    output logic [KEY_W-1:0] a4_key,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic             pt_own
);

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        RD_LEN,
        LEN,
        SCAN,
        FAIL,
        PASS,
        DONE
    } state_t;

    localparam logic [KEY_W-1:0] KEY_LAST = '1;

    state_t           state, state_nxt;
    logic [7:0]       len, len_nxt;
    logic [7:0]       idx, idx_nxt;
    logic             primed, primed_nxt;
    logic             rdy_nxt, key_valid_nxt, a4_en_nxt, pt_own_nxt;
    logic [KEY_W-1:0] key_nxt, a4_key_nxt;
    logic [7:0]       pt_addr_nxt;
    logic             byte_ok;

    assign byte_ok = (pt_rddata >= CHAR_LO) && (pt_rddata <= CHAR_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= 8'd0;
            idx       <= 8'd0;
            primed    <= 1'b0;
            rdy       <= 1'b1;
            key       <= '0;
            key_valid <= 1'b0;
            a4_en     <= 1'b0;
            a4_key    <= KEY_INIT;
            pt_addr   <= 8'd0;
            pt_own    <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            primed    <= primed_nxt;
            rdy       <= rdy_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
            a4_en     <= a4_en_nxt;
            a4_key    <= a4_key_nxt;
            pt_addr   <= pt_addr_nxt;
            pt_own    <= pt_own_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_nxt       = len;
        idx_nxt       = idx;
        primed_nxt    = primed;
        rdy_nxt       = rdy;
        key_nxt       = key;
        key_valid_nxt = key_valid;
        a4_en_nxt     = 1'b0;
        a4_key_nxt    = a4_key;
        pt_addr_nxt   = pt_addr;
        pt_own_nxt    = pt_own;

        case (state)
            IDLE, DONE: begin
                if (en) begin
                    a4_key_nxt    = KEY_INIT;
                    key_valid_nxt = 1'b0;
                    rdy_nxt       = 1'b0;
                    state_nxt     = LAUNCH;
                end
            end
            LAUNCH: begin
                if (a4_rdy) begin
                    a4_en_nxt = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            // arc4 only drops rdy after seeing en, so its rdy is stale here
            WAIT_ACK: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (a4_rdy) begin
                    pt_own_nxt  = 1'b1;
                    pt_addr_nxt = 8'd0;
                    state_nxt   = RD_LEN;
                end
            end
            RD_LEN: state_nxt = LEN;
            LEN: begin
                len_nxt = pt_rddata;
                if (pt_rddata == 8'd0) begin
                    state_nxt = FAIL;
                end else begin
                    pt_addr_nxt = 8'd1;
                    idx_nxt     = 8'd1;
                    primed_nxt  = 1'b0;
                    state_nxt   = SCAN;
                end
            end
            // Address runs one cycle ahead of data; the first cycle only primes the RAM
            SCAN: begin
                if (pt_addr <= len) begin
                    pt_addr_nxt = pt_addr + 8'd1;
                end
                if (!primed) begin
                    primed_nxt = 1'b1;
                end else if (!byte_ok) begin
                    state_nxt = FAIL;
                end else if (idx == len) begin
                    state_nxt = PASS;
                end else begin
                    idx_nxt = idx + 8'd1;
                end
            end
            FAIL: begin
                pt_own_nxt = 1'b0;
                if (a4_key == KEY_LAST) begin
                    rdy_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    a4_key_nxt = a4_key + KEY_W'(1);
                    state_nxt  = LAUNCH;
                end
            end
            PASS: begin
                key_nxt       = a4_key;
                key_valid_nxt = 1'b1;
                pt_own_nxt    = 1'b0;
                rdy_nxt       = 1'b1;
                state_nxt     = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Bench for arc4_crack_ctrl: behavioural arc4 and pt_mem models, table of
// key-search scenarios scoreboarded through a queue, plus reset/busy corners.
module tb_arc4_crack_ctrl;

    localparam int KW = 4;

    logic          clk, rst_n, en, rdy, key_valid, a4_en, a4_rdy, pt_own;
    logic [KW-1:0] key, a4_key;
    logic [7:0]    pt_addr, pt_rddata;

    typedef struct packed {
        int              good_key;
        logic [0:4][7:0] good_msg;
        logic [0:4][7:0] bad_msg;
        logic            exp_valid;
        logic [KW-1:0]   exp_key;
        int              exp_launches;
        int              exp_own;
    } vec_t;

    vec_t tbl [7];
    vec_t exp_q [$];
    vec_t cur_rec;
    int   assertions = 0;
    int   failures   = 0;

    arc4_crack_ctrl #(.KEY_W(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .key_valid (key_valid),
        .a4_en     (a4_en),
        .a4_rdy    (a4_rdy),
        .a4_key    (a4_key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .pt_own    (pt_own)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arc4 stand-in: busy four cycles, then writes the message chosen by the key
    logic [7:0]    mem [0:255];
    logic [2:0]    mdl_cnt;
    logic [KW-1:0] mdl_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a4_rdy  <= 1'b1;
            mdl_cnt <= 3'd0;
            mdl_key <= '0;
        end else if (a4_en && a4_rdy && mdl_cnt == 3'd0) begin
            a4_rdy  <= 1'b0;
            mdl_cnt <= 3'd4;
            mdl_key <= a4_key;
        end else if (mdl_cnt != 3'd0) begin
            mdl_cnt <= mdl_cnt - 3'd1;
            if (mdl_cnt == 3'd1) begin
                a4_rdy <= 1'b1;
                for (int i = 0; i < 5; i++) begin
                    mem[i] <= (int'(mdl_key) == cur_rec.good_key) ? cur_rec.good_msg[i] : cur_rec.bad_msg[i];
                end
            end
        end
    end

    always @(posedge clk) pt_rddata <= mem[pt_addr];

    // Observes launches, key order, a4_key stability and the pt_own window
    int            launch_cnt, seq_err, stab_err, own_cnt;
    logic          prev_rdy, prev_own;
    logic [KW-1:0] held_key;

    always @(negedge clk) begin
        if (!rst_n) begin
            launch_cnt <= 0;
            seq_err    <= 0;
            stab_err   <= 0;
            own_cnt    <= 0;
            prev_rdy   <= 1'b1;
            prev_own   <= 1'b0;
            held_key   <= '0;
        end else begin
            if (prev_rdy && !rdy) begin
                launch_cnt <= 0;
                seq_err    <= 0;
                stab_err   <= 0;
            end
            if (a4_en) begin
                if (a4_key !== KW'(launch_cnt)) seq_err <= seq_err + 1;
                held_key   <= a4_key;
                launch_cnt <= launch_cnt + 1;
            end else if (mdl_cnt != 3'd0 && a4_key !== held_key) begin
                stab_err <= stab_err + 1;
            end
            if (pt_own) own_cnt <= prev_own ? own_cnt + 1 : 1;
            prev_rdy <= rdy;
            prev_own <= pt_own;
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            assertions++;
            failures++;
            $display("[TB] FAIL done_timeout: rdy still 0 after 2000 cycles, expected 1");
        end
    endtask

    task automatic applyStimulus(input vec_t rec);
        @(negedge clk);
        cur_rec = rec;
        exp_q.push_back(rec);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkVal("start_rdy", 32'(rdy), 32'd0);
        checkVal("start_key_valid", 32'(key_valid), 32'd0);
    endtask

    task automatic checkOutput();
        vec_t e;
        bit   ok;
        waitDone(ok);
        if (exp_q.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending record");
        end else begin
            e = exp_q.pop_front();
            if (ok) begin
                checkVal("key_valid", 32'(key_valid), 32'(e.exp_valid));
                checkVal(e.exp_valid ? "key" : "a4_key_final",
                         32'(e.exp_valid ? key : a4_key), 32'(e.exp_key));
                checkVal("launches", launch_cnt, e.exp_launches);
                checkVal("key_order_errs", seq_err, 0);
                checkVal("a4_key_unstable", stab_err, 0);
                checkVal("pt_own_released", 32'(pt_own), 32'd0);
                if (e.exp_own >= 0) checkVal("pt_own_cycles", own_cnt, e.exp_own);
            end
        end
    endtask

    initial begin
        bit found;
        tbl[0] = '{0,  {8'd3, "Hi!", 8'h00},         {8'd1, 8'h07, 24'h0},        1'b1, 4'd0, 1,  7};
        tbl[1] = '{5,  {8'd2, "OK", 16'h0},          {8'd1, 8'h07, 24'h0},        1'b1, 4'd5, 6,  6};
        tbl[2] = '{2,  {8'd2, 8'h20, 8'h7E, 16'h0},  {8'd1, 8'h7F, 24'h0},        1'b1, 4'd2, 3,  6};
        tbl[3] = '{3,  {8'd1, 8'h41, 24'h0},         {8'd0, 32'h41414141},        1'b1, 4'd3, 4,  5};
        tbl[4] = '{1,  {8'd2, "AB", 8'h07, 8'h00},   {8'd3, "AB", 8'h07, 8'h00},  1'b1, 4'd1, 2,  6};
        tbl[5] = '{4,  {8'd1, 8'h7E, 24'h0},         {8'd2, 8'h20, 8'h1F, 16'h0}, 1'b1, 4'd4, 5,  5};
        tbl[6] = '{99, {8'd1, 8'h41, 24'h0},         {8'd1, 8'h7F, 24'h0},        1'b0, 4'hF, 16, -1};

        rst_n   = 1'b0;
        en      = 1'b0;
        cur_rec = tbl[0];
        repeat (2) @(negedge clk);
        checkVal("reset_rdy", 32'(rdy), 32'd1);
        checkVal("reset_key_valid", 32'(key_valid), 32'd0);
        checkVal("reset_a4_en", 32'(a4_en), 32'd0);
        checkVal("reset_pt_own", 32'(pt_own), 32'd0);
        checkVal("reset_a4_key", 32'(a4_key), 32'd0);
        checkVal("reset_pt_addr", 32'(pt_addr), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i]);
            checkOutput();
        end

        // Exhaustion must park on the last key without wrapping
        repeat (3) @(negedge clk);
        checkVal("exhaust_hold_a4_key", 32'(a4_key), 32'hF);
        checkVal("exhaust_hold_rdy", 32'(rdy), 32'd1);
        checkVal("exhaust_hold_key_valid", 32'(key_valid), 32'd0);

        // en while busy in WAIT_DONE of the fourth key must be ignored
        applyStimulus(tbl[1]);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (launch_cnt == 4 && !a4_rdy) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("busy_window_reached", 32'(found), 32'd1);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkVal("busy_en_rdy", 32'(rdy), 32'd0);
        checkOutput();

        // Reset asserted mid-scan aborts straight to reset values
        @(negedge clk);
        cur_rec = tbl[0];
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (pt_own && pt_addr == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("scan_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        checkVal("midscan_rst_rdy", 32'(rdy), 32'd1);
        checkVal("midscan_rst_key", 32'(key), 32'd0);
        checkVal("midscan_rst_pt_own", 32'(pt_own), 32'd0);
        checkVal("midscan_rst_pt_addr", 32'(pt_addr), 32'd0);
        checkVal("midscan_rst_a4_key", 32'(a4_key), 32'd0);
        @(negedge clk);
        checkVal("midscan_rst_a4_en", 32'(a4_en), 32'd0);
        checkVal("midscan_rst_key_valid", 32'(key_valid), 32'd0);
        rst_n = 1'b1;

        applyStimulus(tbl[0]);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
